// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// mux selects and the control-output bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       illegal;
        logic       instrdone;
    } ctrl_t;

    // DECODE dispatch; an unsupported opcode falls back to FETCH.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:    decode_next = S_MEMADR;
            OP_RTYPE:        decode_next = S_EXEC;
            OP_BEQ, OP_BNE:  decode_next = S_BRANCH;
            OP_ADDI:         decode_next = S_ADDIEX;
            OP_J:            decode_next = S_JUMP;
            OP_JAL:          decode_next = S_JAL;
            default:         decode_next = S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational control decode: Moore outputs per state, plus the Zero-driven
// branch enable and the live-opcode Illegal flag in DECODE.
module mips_mc_outdec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] op_q,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread  = 1'b1;
                ctrl.irwrite  = 1'b1;
                ctrl.alusrcb  = SRCB_4;
                ctrl.aluop    = ALU_ADD;
                ctrl.pcsource = PCS_ALU;
                ctrl.pcen     = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.illegal = (decode_next(opcode) == S_FETCH);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite  = 1'b1;
                ctrl.regdst    = RD_RT;
                ctrl.memtoreg  = M2R_MDR;
                ctrl.instrdone = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memwrite  = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.instrdone = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regwrite  = 1'b1;
                ctrl.regdst    = RD_RD;
                ctrl.memtoreg  = M2R_ALUOUT;
                ctrl.instrdone = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca   = 1'b1;
                ctrl.alusrcb   = SRCB_B;
                ctrl.aluop     = ALU_SUB;
                ctrl.pcsource  = PCS_ALUOUT;
                ctrl.pcen      = (op_q == OP_BNE) ? ~zero : zero;
                ctrl.instrdone = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.regwrite  = 1'b1;
                ctrl.regdst    = RD_RT;
                ctrl.memtoreg  = M2R_ALUOUT;
                ctrl.instrdone = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcen      = 1'b1;
                ctrl.pcsource  = PCS_JUMP;
                ctrl.instrdone = 1'b1;
            end
            S_JAL: begin
                // PC already advanced in FETCH, so writing PC links the return address.
                ctrl.pcen      = 1'b1;
                ctrl.pcsource  = PCS_JUMP;
                ctrl.regwrite  = 1'b1;
                ctrl.regdst    = RD_RA;
                ctrl.memtoreg  = M2R_PC;
                ctrl.instrdone = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: state register, opcode latched in DECODE,
// retired-instruction counter; output decode lives in mips_mc_outdec.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic        Zero,
    output logic        PCEn,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        Illegal,
    output logic        InstrDone,
    output logic [31:0] InstRet,
    output logic [3:0]  State
);

    state_t      state;
    logic [5:0]  op_q;
    logic [31:0] instret_q;
    ctrl_t       ctrl;

    mips_mc_outdec u_outdec (
        .state  (state),
        .opcode (Opcode),
        .op_q   (op_q),
        .zero   (Zero),
        .ctrl   (ctrl)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            op_q      <= '0;
            instret_q <= '0;
        end else begin
            if (ctrl.instrdone)
                instret_q <= instret_q + 32'd1;
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    op_q  <= Opcode;
                    state <= decode_next(Opcode);
                end
                S_MEMADR: state <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state <= S_MEMWB;
                S_EXEC:   state <= S_ALUWB;
                S_ADDIEX: state <= S_ADDIWB;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Side-effecting strobes are held off during reset so an abandoned
    // instruction cannot touch PC, IR, memory or the register file.
    assign PCEn      = ctrl.pcen      & ~reset;
    assign MemRead   = ctrl.memread   & ~reset;
    assign MemWrite  = ctrl.memwrite  & ~reset;
    assign IRWrite   = ctrl.irwrite   & ~reset;
    assign RegWrite  = ctrl.regwrite  & ~reset;
    assign Illegal   = ctrl.illegal   & ~reset;
    assign InstrDone = ctrl.instrdone & ~reset;

    assign IorD     = ctrl.iord;
    assign RegDst   = ctrl.regdst;
    assign MemtoReg = ctrl.memtoreg;
    assign ALUSrcA  = ctrl.alusrca;
    assign ALUSrcB  = ctrl.alusrcb;
    assign ALUOp    = ctrl.aluop;
    assign PCSource = ctrl.pcsource;
    assign InstRet  = instret_q;
    assign State    = state;

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle MIPS control unit that sequences each instruction through fetch, decode, execute, memory and write-back states. Drives the register file write port (RegWrite, RegDst, MemtoReg) together with PC, IR, memory and ALU-mux controls. Sits directly upstream of the register file and next to the shared instruction/data memory. Maintains an instruction-retired counter for test and debug.

## Interface
- No parameters; all encodings come from the shared package.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- Opcode  in  6  IR[31:26], stable from DECODE onward.
- Zero  in  1  ALU zero flag, valid in BRANCH.
- PCEn  out  1  PC register load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead / MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  instruction register load.
- RegWrite  out  1  register file write enable.
- RegDst  out  2  write address select: 00 = rt, 01 = rd, 10 = 31.
- MemtoReg  out  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = use funct.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- Illegal  out  1  one-cycle pulse on an unsupported opcode.
- InstrDone  out  1  one-cycle pulse in an instruction's final state.
- InstRet  out  32  retired-instruction count.
- State  out  4  current state, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010, jal 000011.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, JAL 12.
- FETCH: MemRead, IRWrite, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00, PCEn = 1. Next state: DECODE.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (computes the branch target). Next state depends on opcode:
  - lw / sw → MEMADR
  - R-type → EXEC
  - beq / bne → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - jal → JAL
  - anything else → FETCH, with an Illegal pulse in this DECODE cycle.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead, IorD = 1. Next: MEMWB.
- MEMWB: RegWrite, RegDst = 00, MemtoReg = 01. Next: FETCH.
- MEMWR: MemWrite, IorD = 1. Next: FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next: ALUWB.
- ALUWB: RegWrite, RegDst = 01, MemtoReg = 00. Next: FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSource = 01.
  - beq: PCEn = Zero.
  - bne: PCEn = ~Zero.
  - Next: FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next: ADDIWB.
- ADDIWB: RegWrite, RegDst = 00, MemtoReg = 00. Next: FETCH.
- JUMP: PCEn, PCSource = 10. Next: FETCH.
- JAL: PCEn, PCSource = 10, RegWrite, RegDst = 10, MemtoReg = 10 (PC already holds PC+4). Next: FETCH.
- Any output not listed for a state is 0.
- Opcode is registered in DECODE. MEMADR, BRANCH and later states use the registered copy, never the live input.
- InstrDone is asserted in: MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP, JAL.
- InstRet increments on every cycle with InstrDone high. It is modulo 2^32: 0xFFFFFFFF wraps to 0. Illegal instructions are not counted.
- Writes to $0 are not filtered here; the register file discards them.

## Timing
- Moore outputs decoded from State. The only exceptions are PCEn in BRANCH (combinational on Zero) and Illegal (combinational on Opcode in DECODE).
- Cycles per instruction, counted from FETCH: lw 5; sw, R-type and addi 4; beq, bne, j and jal 3; illegal 2.
- Reset asserted at an edge: State ← FETCH, stored opcode ← 0, InstRet ← 0.
- While reset is high, PCEn, IRWrite, MemWrite, RegWrite, MemRead, Illegal and InstrDone are forced to 0. This applies even mid-instruction; a partial instruction is abandoned.
- First cycle after reset deasserts: FETCH outputs.

## Structure
- Shared package mips_pkg holds:
  - opcode constants;
  - state encoding;
  - ALUOp, RegDst, MemtoReg, ALUSrcB and PCSource encodings.
- Optional sub-module mips_mc_outdec: purely combinational mapping from state, stored opcode and Zero to the control outputs. The top level holds the state register, stored opcode and InstRet.

## Test plan
- Reset held 3 cycles then released → State = 0, InstRet = 0, all write enables 0 during reset; FETCH outputs (PCEn = 1, IRWrite = 1, MemRead = 1) on the first cycle after release.
- Opcode 100011 (lw) → states 0, 1, 2, 3, 4. RegWrite = 1 with RegDst = 00 and MemtoReg = 01 only in state 4. InstRet increments by 1.
- Opcode 000100 (beq):
  - with Zero = 1 in BRANCH → PCEn = 1, PCSource = 01;
  - repeated with Zero = 0 → PCEn = 0.
  - 3 cycles each in both cases.
- Opcode 000011 (jal) → state 12 shows PCEn = 1, RegWrite = 1, RegDst = 10, MemtoReg = 10, PCSource = 10.
- Opcode 111111 → Illegal pulses for 1 cycle in DECODE, state returns to FETCH, InstRet unchanged. Reset asserted during MEMRD of a lw → no RegWrite, State = 0 next cycle.
- Preload InstRet near wrap by running 0xFFFFFFFF instructions, or force the counter in simulation, then retire one R-type → InstRet = 0.
